uart_tx_scheduler: RTL and testbench

- Shares the single UART transmit FIFO write port between four 8-bit message sources: game state/connect, shot position, keeper position and score.
- Sends a source's byte only when its value differs from the last byte sent for that source. Arbitration is round-robin.
- Enforces a minimum gap between writes and honours tx_full.
- Sits between the game-logic data_to_transmit outputs and the uart w_data/wr_uart inputs.

---
 rtl/uart_tx_scheduler.sv | 149 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX FIFO write port between four byte sources.
// Define UART_TX_REFRESH_EN to retransmit every source periodically as a keep-alive.
module uart_tx_scheduler #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned REFRESH_CYCLES = 6_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] data_src0,
    input  logic [7:0] data_src1,
    input  logic [7:0] data_src2,
    input  logic [7:0] data_src3,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    output logic [3:0] pending,
    output logic       busy
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StGap} state_e;

    state_e            state_q, state_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [1:0]        rr_q, rr_d;
    logic [7:0]        w_data_q, w_data_d;
    logic              wr_q, wr_d;
    logic [3:0][7:0]   sent_q, sent_d;
    logic [3:0][7:0]   src;
    logic [3:0]        force_flags;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [1:0]        scan_idx;
    logic              issue;

    assign src = {data_src3, data_src2, data_src1, data_src0};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pending[i] = (src[i] != sent_q[i]) | force_flags[i];
        end
    end

    // Scan from the farthest offset down so the nearest pending source wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_q;
        scan_idx    = '0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_q + 2'(k);
            if (pending[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign issue = (state_q == StIdle) && tx_en && !tx_full && grant_valid;

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        rr_d     = rr_q;
        w_data_d = w_data_q;
        wr_d     = 1'b0;
        sent_d   = sent_q;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    w_data_d          = src[grant_idx];
                    wr_d              = 1'b1;
                    sent_d[grant_idx] = src[grant_idx];
                    rr_d              = grant_idx + 2'd1;
                    gap_d             = GapW'(GAP_CYCLES - 1);
                    state_d           = StGap;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            rr_q     <= '0;
            w_data_q <= '0;
            wr_q     <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            rr_q     <= rr_d;
            w_data_q <= w_data_d;
            wr_q     <= wr_d;
            sent_q   <= sent_d;
        end
    end

`ifdef UART_TX_REFRESH_EN
    localparam int unsigned RefW = $clog2(REFRESH_CYCLES + 1);

    logic [RefW-1:0] refresh_q, refresh_d;
    logic            refresh_wrap;
    logic [3:0]      force_q, force_d;

    assign refresh_wrap = (refresh_q == RefW'(REFRESH_CYCLES - 1));
    assign refresh_d    = refresh_wrap ? '0 : refresh_q + 1'b1;

    // A wrap on the grant cycle wins so the keep-alive is never lost.
    always_comb begin
        force_d = force_q;
        if (issue) begin
            force_d[grant_idx] = 1'b0;
        end
        if (refresh_wrap) begin
            force_d = 4'hF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            force_q   <= '0;
        end else begin
            refresh_q <= refresh_d;
            force_q   <= force_d;
        end
    end

    assign force_flags = force_q;
`else
    assign force_flags = 4'h0;
`endif

    assign w_data  = w_data_q;
    assign wr_uart = wr_q;
    assign busy    = (state_q == StGap);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed testbench for uart_tx_scheduler: change detection, round-robin order,
// gap spacing, tx_full/tx_en blocking, coalescing and reset behaviour.
module tb_uart_tx_scheduler;

    localparam int unsigned GAP = 16;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic [7:0] data_src0, data_src1, data_src2, data_src3;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [3:0] pending;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [7:0] strobe_data[$];
    int         strobe_cyc[$];

    uart_tx_scheduler #(
        .GAP_CYCLES    (GAP),
        .REFRESH_CYCLES(200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .data_src0(data_src0),
        .data_src1(data_src1),
        .data_src2(data_src2),
        .data_src3(data_src3),
        .tx_full  (tx_full),
        .w_data   (w_data),
        .wr_uart  (wr_uart),
        .pending  (pending),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log, sampled on the inactive edge.
    always @(negedge clk) begin
        if (wr_uart) begin
            strobe_data.push_back(w_data);
            strobe_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        strobe_data.delete();
        strobe_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_en = 1'b1; tx_full = 1'b0;
        data_src0 = 8'h00; data_src1 = 8'h00; data_src2 = 8'h00; data_src3 = 8'h00;
        tick(3);
        vectors++;
        if (wr_uart !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", wr_uart); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++;
        if (w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h exp=00", w_data); end
        rst = 1'b0;
        clear_log();
        tick(1000);
        vectors++;
        if (strobe_data.size() !== 0) begin
            errors++; $display("FAIL idle_strobes got=%0d exp=0", strobe_data.size());
        end
        vectors++;
        if (pending !== 4'h0) begin errors++; $display("FAIL idle_pending got=%h exp=0", pending); end
    endtask

    task automatic test_single();
        clear_log();
        data_src1 = 8'h2A;
        #1;
        vectors++;
        if (pending !== 4'b0010) begin errors++; $display("FAIL single_pending got=%b exp=0010", pending); end
        tick(1);
        vectors++;
        if (wr_uart !== 1'b1 || w_data !== 8'h2A) begin
            errors++; $display("FAIL single_strobe got=%b/%h exp=1/2a", wr_uart, w_data);
        end
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        tick(1);
        vectors++;
        if (wr_uart !== 1'b0) begin errors++; $display("FAIL single_pulse_width got=%b exp=0", wr_uart); end
        tick(100);
        vectors++;
        if (strobe_data.size() !== 1) begin
            errors++; $display("FAIL single_count got=%0d exp=1", strobe_data.size());
        end
    endtask

    task automatic test_all_four();
        logic [7:0] exp_data[4];
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1;
        data_src0 = 8'h11; data_src1 = 8'h22; data_src2 = 8'h33; data_src3 = 8'h44;
        tick(1);
        clear_log();
        rst = 1'b0;
        tick(100);
        vectors++;
        if (strobe_data.size() !== 4) begin
            errors++; $display("FAIL rr_count got=%0d exp=4", strobe_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (strobe_data[i] !== exp_data[i]) begin
                    errors++; $display("FAIL rr_order[%0d] got=%h exp=%h", i, strobe_data[i], exp_data[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (strobe_cyc[i] - strobe_cyc[i-1] !== GAP + 1) begin
                    errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", i,
                                       strobe_cyc[i] - strobe_cyc[i-1], GAP + 1);
                end
            end
        end
    endtask

    task automatic test_full();
        clear_log();
        tx_full = 1'b1;
        data_src2 = 8'h05;
        tick(50);
        vectors++;
        if (strobe_data.size() !== 0) begin
            errors++; $display("FAIL full_block got=%0d exp=0", strobe_data.size());
        end
        vectors++;
        if (w_data !== 8'h44) begin errors++; $display("FAIL full_hold_wdata got=%h exp=44", w_data); end
        tx_full = 1'b0;
        tick(1);
        vectors++;
        if (wr_uart !== 1'b1 || w_data !== 8'h05) begin
            errors++; $display("FAIL full_release got=%b/%h exp=1/05", wr_uart, w_data);
        end
    endtask

    task automatic test_coalesce();
        // Entered directly after a strobe, so the FSM is in GAP.
        data_src3 = 8'h01; tick(1);
        data_src3 = 8'h02; tick(1);
        data_src3 = 8'h03;
        tick(60);
        vectors++;
        if (strobe_data.size() !== 2) begin
            errors++; $display("FAIL coalesce_count got=%0d exp=2", strobe_data.size());
        end else begin
            vectors++;
            if (strobe_data[1] !== 8'h03) begin
                errors++; $display("FAIL coalesce_data got=%h exp=03", strobe_data[1]);
            end
            vectors++;
            if (strobe_cyc[1] - strobe_cyc[0] !== GAP + 1) begin
                errors++; $display("FAIL coalesce_spacing got=%0d exp=%0d",
                                   strobe_cyc[1] - strobe_cyc[0], GAP + 1);
            end
        end
    endtask

    task automatic test_tx_en();
        clear_log();
        tx_en = 1'b0;
        data_src0 = 8'h99;
        tick(30);
        vectors++;
        if (strobe_data.size() !== 0) begin
            errors++; $display("FAIL txen_block got=%0d exp=0", strobe_data.size());
        end
        vectors++;
        if (pending !== 4'b0001) begin errors++; $display("FAIL txen_pending got=%b exp=0001", pending); end
        tx_en = 1'b1;
        tick(1);
        vectors++;
        if (wr_uart !== 1'b1 || w_data !== 8'h99) begin
            errors++; $display("FAIL txen_release got=%b/%h exp=1/99", wr_uart, w_data);
        end
        tick(40);
    endtask

    task automatic test_reset_mid_gap();
        data_src1 = 8'h77;
        tick(1);
        vectors++;
        if (wr_uart !== 1'b1 || w_data !== 8'h77) begin
            errors++; $display("FAIL midgap_strobe got=%b/%h exp=1/77", wr_uart, w_data);
        end
        tick(5);
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || wr_uart !== 1'b0 || w_data !== 8'h00) begin
            errors++; $display("FAIL midgap_reset got=%b/%b/%h exp=0/0/00", busy, wr_uart, w_data);
        end
        vectors++;
        if (pending !== 4'hF) begin errors++; $display("FAIL midgap_pending got=%h exp=f", pending); end
        tick(1);
        rst = 1'b0;
        tick(1);
        vectors++;
        if (wr_uart !== 1'b1 || w_data !== 8'h99) begin
            errors++; $display("FAIL midgap_restart got=%b/%h exp=1/99", wr_uart, w_data);
        end
        tick(100);
    endtask

    task automatic test_refresh();
        clear_log();
        tick(500);
`ifdef UART_TX_REFRESH_EN
        vectors++;
        if (strobe_data.size() < 8) begin
            errors++; $display("FAIL refresh_count got=%0d exp>=8", strobe_data.size());
        end
`else
        vectors++;
        if (strobe_data.size() !== 0) begin
            errors++; $display("FAIL refresh_none got=%0d exp=0", strobe_data.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_full();
        test_coalesce();
        test_tx_en();
        test_reset_mid_gap();
        test_refresh();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
